// File: rtl/ychg_pkg.sv
// Shared types and widths for the Y-matrix change scheduler.
package ychg_pkg;

    localparam int unsigned ROW_W   = 16;
    localparam int unsigned CPLX_W  = 24;
    localparam int unsigned YWORD_W = 256;
    localparam int unsigned RSVD_W  = 8;
    localparam int unsigned CHG_W   = 2 * ROW_W + 2 * CPLX_W + RSVD_W;

    localparam logic [1:0] GNT_FREE = 2'b00;
    localparam logic [1:0] GNT_FILT = 2'b01;
    localparam logic [1:0] GNT_EXT  = 2'b10;

    typedef struct packed {
        logic [ROW_W-1:0]  row;
        logic [ROW_W-1:0]  col;
        logic [CPLX_W-1:0] re;
        logic [CPLX_W-1:0] im;
    } chg_rec_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_ISSUE = 3'd3,
        ST_WAIT  = 3'd4,
        ST_NEXT  = 3'd5,
        ST_DONE  = 3'd6,
        ST_ABORT = 3'd7
    } sched_state_t;

endpackage

// File: rtl/ymem_rr_arb.sv
// Two-requester locking round-robin arbiter for the Y-memory read port.
// A grant is held until the owner releases; filt can also be flushed on abort.
module ymem_rr_arb
    import ychg_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       reqFilt,
    input  logic       relFilt,
    input  logic       flushFilt,
    input  logic       reqExt,
    input  logic       relExt,
    output logic [1:0] gnt
);

    logic [1:0] gntNext;
    logic       extFirst;
    logic       extFirstNext;

    // Release wins over a simultaneous request; new grants only from the free state.
    always_comb begin
        gntNext      = gnt;
        extFirstNext = extFirst;
        if (gnt[0]) begin
            if (relFilt || flushFilt) gntNext = GNT_FREE;
        end else if (gnt[1]) begin
            if (relExt) gntNext = GNT_FREE;
        end else if (reqFilt && !flushFilt && !(reqExt && extFirst)) begin
            gntNext      = GNT_FILT;
            extFirstNext = 1'b1;
        end else if (reqExt) begin
            gntNext      = GNT_EXT;
            extFirstNext = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            gnt      <= GNT_FREE;
            extFirst <= 1'b0;
        end else begin
            gnt      <= gntNext;
            extFirst <= extFirstNext;
        end
    end

endmodule

// File: rtl/ychg_sched.sv
// Walks change records through filt_yVal one at a time, with a per-change
// watchdog, and shares the Y-memory read port with an external requester.
module ychg_sched
    import ychg_pkg::*;
#(
    parameter int unsigned AW      = 8,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [AW:0]       num_chg,
    output logic              chg_rd_en,
    output logic [AW-1:0]     chg_addr,
    input  logic [CHG_W-1:0]  chg_rdata,
    output logic              filt_EN,
    output logic [ROW_W-1:0]  chng_row,
    output logic [ROW_W-1:0]  chng_col,
    output logic [CPLX_W-1:0] chng_real,
    output logic [CPLX_W-1:0] chng_img,
    input  logic              filt_done,
    input  logic              filt_req,
    input  logic [ROW_W-1:0]  filt_row,
    input  logic              filt_rel,
    input  logic              ext_req,
    input  logic [ROW_W-1:0]  ext_row,
    input  logic              ext_rel,
    output logic              ymem_rd_en,
    output logic [ROW_W-1:0]  ymem_row,
    input  logic              ymem_rdy,
    output logic              filt_rdy,
    output logic              ext_rdy,
    output logic [1:0]        gnt,
    output logic              busy,
    output logic              all_done,
    output logic              timeout_err,
    output logic [AW:0]       chg_count
);

    localparam int unsigned CW  = AW + 1;
    localparam int unsigned WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    sched_state_t   state, stateNext;
    logic [CW-1:0]  idx, idxNext;
    logic [CW-1:0]  numChgR, numChgNext;
    logic [CW-1:0]  countNext;
    logic [WDW-1:0] wdCnt, wdNext;
    logic           errNext;
    logic           zeroDone;
    logic           chgRdEnNext, filtEnNext, busyNext, allDoneNext, flushFilt;
    logic [AW-1:0]  chgAddrNext;
    chg_rec_t       rec;
    logic           unusedRsvd;

    assign unusedRsvd = ^chg_rdata[RSVD_W-1:0];

    // Next state plus the next value of every registered output.
    always_comb begin
        stateNext  = state;
        idxNext    = idx;
        numChgNext = numChgR;
        countNext  = chg_count;
        wdNext     = wdCnt;
        errNext    = timeout_err;
        zeroDone   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    errNext    = 1'b0;
                    countNext  = '0;
                    idxNext    = '0;
                    numChgNext = num_chg;
                    if (num_chg == '0) zeroDone  = 1'b1;
                    else               stateNext = ST_FETCH;
                end
            end
            ST_FETCH: stateNext = ST_LOAD;
            ST_LOAD: begin
                stateNext = ST_ISSUE;
                wdNext    = '0;
            end
            ST_ISSUE: begin
                stateNext = ST_WAIT;
                if (TIMEOUT != 0) wdNext = wdCnt + WDW'(1);
            end
            ST_WAIT: begin
                if (filt_done) begin
                    stateNext = ST_NEXT;
                    if (chg_count < numChgR) countNext = chg_count + CW'(1);
                end else if (TIMEOUT != 0 && wdCnt >= WDW'(TIMEOUT - 1)) begin
                    stateNext = ST_ABORT;
                    errNext   = 1'b1;
                end else if (TIMEOUT != 0) begin
                    wdNext = wdCnt + WDW'(1);
                end
            end
            ST_NEXT: begin
                if (idx < numChgR) idxNext = idx + CW'(1);
                stateNext = (idxNext == numChgR) ? ST_DONE : ST_FETCH;
            end
            ST_DONE:  stateNext = ST_IDLE;
            ST_ABORT: stateNext = ST_IDLE;
            default:  stateNext = ST_IDLE;
        endcase

        chgRdEnNext = (stateNext == ST_FETCH);
        filtEnNext  = (stateNext == ST_ISSUE) || (stateNext == ST_WAIT);
        busyNext    = (stateNext != ST_IDLE);
        allDoneNext = zeroDone || (stateNext == ST_DONE) || (stateNext == ST_ABORT);
        flushFilt   = (stateNext == ST_ABORT);
        chgAddrNext = chgRdEnNext ? idxNext[AW-1:0] : chg_addr;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            idx         <= '0;
            numChgR     <= '0;
            wdCnt       <= '0;
            chg_count   <= '0;
            timeout_err <= 1'b0;
            chg_rd_en   <= 1'b0;
            chg_addr    <= '0;
            filt_EN     <= 1'b0;
            busy        <= 1'b0;
            all_done    <= 1'b0;
            rec         <= '0;
        end else begin
            state       <= stateNext;
            idx         <= idxNext;
            numChgR     <= numChgNext;
            wdCnt       <= wdNext;
            chg_count   <= countNext;
            timeout_err <= errNext;
            chg_rd_en   <= chgRdEnNext;
            chg_addr    <= chgAddrNext;
            filt_EN     <= filtEnNext;
            busy        <= busyNext;
            all_done    <= allDoneNext;
            if (state == ST_LOAD) rec <= chg_rec_t'(chg_rdata[CHG_W-1:RSVD_W]);
        end
    end

    assign chng_row  = rec.row;
    assign chng_col  = rec.col;
    assign chng_real = rec.re;
    assign chng_img  = rec.im;

    ymem_rr_arb uArb (
        .clock     (clock),
        .reset     (reset),
        .reqFilt   (filt_req & filt_EN),
        .relFilt   (filt_rel),
        .flushFilt (flushFilt),
        .reqExt    (ext_req),
        .relExt    (ext_rel),
        .gnt       (gnt)
    );

    // Memory-side handshake follows the registered grant within the cycle.
    assign ymem_rd_en = (gnt[0] & filt_req & filt_EN) | (gnt[1] & ext_req);
    assign ymem_row   = gnt[1] ? ext_row : (gnt[0] ? filt_row : '0);
    assign filt_rdy   = ymem_rdy & gnt[0];
    assign ext_rdy    = ymem_rdy & gnt[1];

endmodule

// File: tb/tb_ychg_sched.sv
// Self-checking bench for ychg_sched: change-RAM and filt_yVal models,
// table vectors, arbiter/abort/reset sequences and randomized runs.
module tb_ychg_sched;

    localparam int unsigned AW = 8;
    localparam int TOUT = 16;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [AW:0]  num_chg = '0;
    logic         chg_rd_en;
    logic [AW-1:0] chg_addr;
    logic [87:0]  chg_rdata = '0;
    logic         filt_EN;
    logic [15:0]  chng_row, chng_col;
    logic [23:0]  chng_real, chng_img;
    logic         filt_done = 1'b0;
    logic         filt_req = 1'b0;
    logic [15:0]  filt_row = '0;
    logic         filt_rel = 1'b0;
    logic         ext_req = 1'b0;
    logic [15:0]  ext_row = '0;
    logic         ext_rel = 1'b0;
    logic         ymem_rd_en;
    logic [15:0]  ymem_row;
    logic         ymem_rdy = 1'b0;
    logic         filt_rdy, ext_rdy;
    logic [1:0]   gnt;
    logic         busy, all_done, timeout_err;
    logic [AW:0]  chg_count;

    logic [87:0]  ram [0:255];
    int           dq[$];
    int           compared = 0;
    int           mismatched = 0;
    int           respCnt = 0;
    int           respDelay = 99;
    logic         respPrev = 1'b0;
    logic [122:0] allOut;

    assign allOut = {chg_rd_en, chg_addr, filt_EN, chng_row, chng_col, chng_real, chng_img,
                     ymem_rd_en, ymem_row, filt_rdy, ext_rdy, gnt, busy, all_done,
                     timeout_err, chg_count};

    ychg_sched #(.AW(AW), .TIMEOUT(TOUT)) dut (
        .clock(clock), .reset(reset), .start(start), .num_chg(num_chg),
        .chg_rd_en(chg_rd_en), .chg_addr(chg_addr), .chg_rdata(chg_rdata),
        .filt_EN(filt_EN), .chng_row(chng_row), .chng_col(chng_col),
        .chng_real(chng_real), .chng_img(chng_img), .filt_done(filt_done),
        .filt_req(filt_req), .filt_row(filt_row), .filt_rel(filt_rel),
        .ext_req(ext_req), .ext_row(ext_row), .ext_rel(ext_rel),
        .ymem_rd_en(ymem_rd_en), .ymem_row(ymem_row), .ymem_rdy(ymem_rdy),
        .filt_rdy(filt_rdy), .ext_rdy(ext_rdy), .gnt(gnt), .busy(busy),
        .all_done(all_done), .timeout_err(timeout_err), .chg_count(chg_count)
    );

    always #5 clock = ~clock;

    // Change RAM: one-cycle read latency.
    always @(posedge clock) if (chg_rd_en) chg_rdata <= ram[chg_addr];

    // filt_yVal stand-in: pulses filt_done a queued number of cycles after filt_EN rises.
    always @(negedge clock) begin
        if (filt_EN && !respPrev) begin
            respCnt = 0;
            if (dq.size() > 0) respDelay = dq.pop_front();
            else               respDelay = 99;
        end else if (filt_EN) begin
            respCnt++;
        end
        filt_done = filt_EN && (respCnt == respDelay);
        respPrev  = filt_EN;
    end

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic fillRam();
        for (int i = 0; i < 256; i++) ram[i] = {24'($urandom), 32'($urandom), 32'($urandom)};
    endtask

    // One run checked against a cycle-budget model of the sequencing rules.
    task automatic doRun(input int n, input int dl[8], output int gotCount, output int gotTo,
                         output int gotDoneAt);
        int offset, completed, aborted, doneAt, fetches, rises, highLen, lowLen, seenDone, expLen;
        logic prevEn;
        logic [87:0] word;
        logic [79:0] held;
        offset = 0; completed = 0; aborted = 0;
        for (int i = 0; i < n; i++) begin
            if (dl[i] >= 1 && dl[i] <= TOUT - 1) begin
                offset += dl[i] + 4;
                completed++;
            end else begin
                offset += 3 + TOUT;
                aborted = 1;
                break;
            end
        end
        doneAt = (aborted != 0) ? offset : offset + 1;
        dq.delete();
        for (int i = 0; i < n; i++) dq.push_back(dl[i]);
        fetches = 0; rises = 0; highLen = 0; lowLen = 0; seenDone = 0; gotDoneAt = -1;
        prevEn = 1'b0; held = '0;
        @(negedge clock);
        start = 1'b1;
        num_chg = (AW+1)'(n);
        for (int cyc = 1; cyc <= doneAt + 4; cyc++) begin
            @(negedge clock);
            start = 1'b0;
            if (chg_rd_en) begin
                check("chg_addr", chg_addr, fetches);
                fetches++;
            end
            if (filt_EN && !prevEn) begin
                rises++;
                if (rises > 1) check("en_gap", lowLen, 3);
                word = ram[rises-1];
                held = word[87:8];
                check("chng_rec", {chng_row, chng_col, chng_real, chng_img}, held);
            end else if (filt_EN) begin
                check("chng_hold", {chng_row, chng_col, chng_real, chng_img}, held);
            end
            if (!filt_EN && prevEn && rises > 0) begin
                expLen = (dl[rises-1] >= 1 && dl[rises-1] <= TOUT - 1) ? dl[rises-1] + 1 : TOUT;
                check("en_len", highLen, expLen);
                highLen = 0;
                lowLen = 0;
            end
            if (filt_EN) highLen++;
            else         lowLen++;
            if (all_done) begin
                seenDone++;
                if (gotDoneAt < 0) gotDoneAt = cyc;
                check("done_cyc", cyc, doneAt);
            end
            if (n == 0) check("busy_zero", busy, 0);
            prevEn = filt_EN;
        end
        check("done_pulses", seenDone, 1);
        check("fetches", fetches, completed + aborted);
        check("chg_count", chg_count, completed);
        check("timeout_err", timeout_err, aborted);
        check("busy_end", busy, 0);
        gotCount = int'(chg_count);
        gotTo = int'(timeout_err);
    endtask

    task automatic startRun(input int n);
        @(negedge clock);
        start = 1'b1;
        num_chg = (AW+1)'(n);
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic waitEn();
        int k;
        k = 0;
        while (!filt_EN && k < 40) begin
            @(negedge clock);
            k++;
        end
        check("en_seen", filt_EN, 1);
    endtask

    task automatic waitDone();
        int k;
        k = 0;
        while (!all_done && k < 60) begin
            @(negedge clock);
            k++;
        end
        check("all_done_seen", all_done, 1);
    endtask

    typedef struct {
        int n;
        int d0, d1, d2, d3;
        int expCount;
        int expTo;
        int expDoneAt;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int dl[8];
        int gc, gt, gd;
        vecs[0] = '{n:1, d0:8,  d1:0,  d2:0, d3:0, expCount:1, expTo:0, expDoneAt:13};
        vecs[1] = '{n:3, d0:5,  d1:5,  d2:5, d3:0, expCount:3, expTo:0, expDoneAt:28};
        vecs[2] = '{n:0, d0:0,  d1:0,  d2:0, d3:0, expCount:0, expTo:0, expDoneAt:1};
        vecs[3] = '{n:2, d0:3,  d1:99, d2:0, d3:0, expCount:1, expTo:1, expDoneAt:26};
        vecs[4] = '{n:1, d0:15, d1:0,  d2:0, d3:0, expCount:1, expTo:0, expDoneAt:20};
        vecs[5] = '{n:1, d0:16, d1:0,  d2:0, d3:0, expCount:0, expTo:1, expDoneAt:19};
        vecs[6] = '{n:2, d0:1,  d1:1,  d2:0, d3:0, expCount:2, expTo:0, expDoneAt:11};

        repeat (2) @(negedge clock);
        check("reset_state", allOut, 0);
        reset = 1'b0;
        @(negedge clock);
        check("post_reset_idle", allOut, 0);

        for (int i = 0; i < 7; i++) begin
            fillRam();
            if (i == 0) ram[0] = 88'h0000_0010_4ebd90_5c2e27_00;
            dl = '{vecs[i].d0, vecs[i].d1, vecs[i].d2, vecs[i].d3, 0, 0, 0, 0};
            doRun(vecs[i].n, dl, gc, gt, gd);
            check("tbl_count", gc, vecs[i].expCount);
            check("tbl_timeout", gt, vecs[i].expTo);
            check("tbl_done_at", gd, vecs[i].expDoneAt);
        end

        // Arbitration: tie, locked grant, release-wins, round-robin turnover.
        dq.delete();
        dq.push_back(15);
        startRun(1);
        waitEn();
        filt_req = 1'b1; filt_row = 16'h0010;
        ext_req = 1'b1;  ext_row = 16'h0056;
        @(negedge clock);
        check("tie_gnt", gnt, 2'b01);
        check("tie_row", ymem_row, 16'h0010);
        check("tie_rd_en", ymem_rd_en, 1);
        ymem_rdy = 1'b1;
        #1;
        check("filt_rdy_own", {filt_rdy, ext_rdy}, 2'b10);
        ymem_rdy = 1'b0;
        filt_rel = 1'b1;
        @(negedge clock);
        filt_rel = 1'b0;
        check("rel_free", gnt, 2'b00);
        @(negedge clock);
        check("rr_gnt_ext", gnt, 2'b10);
        check("rr_row_ext", ymem_row, 16'h0056);
        ymem_rdy = 1'b1;
        #1;
        check("ext_rdy_own", {filt_rdy, ext_rdy}, 2'b01);
        ymem_rdy = 1'b0;
        ext_rel = 1'b1;
        @(negedge clock);
        ext_rel = 1'b0;
        check("ext_rel_free", gnt, 2'b00);
        @(negedge clock);
        check("rr_gnt_filt", gnt, 2'b01);
        check("rr_row_filt", ymem_row, 16'h0010);
        filt_rel = 1'b1; filt_req = 1'b0; ext_req = 1'b0;
        @(negedge clock);
        filt_rel = 1'b0;
        check("all_free", gnt, 2'b00);
        waitDone();

        // filt_req ignored while filt_EN is low.
        @(negedge clock);
        filt_req = 1'b1;
        repeat (3) @(negedge clock);
        check("idle_filt_gnt", gnt, 2'b00);
        check("idle_filt_rd", ymem_rd_en, 0);
        filt_req = 1'b0;

        // Watchdog abort force-releases a held filt grant.
        dq.delete();
        dq.push_back(99);
        startRun(1);
        waitEn();
        filt_req = 1'b1; filt_row = 16'h0033;
        @(negedge clock);
        check("abort_pre_gnt", gnt, 2'b01);
        waitDone();
        check("abort_gnt", gnt, 2'b00);
        check("abort_en", filt_EN, 0);
        check("abort_err", timeout_err, 1);
        filt_req = 1'b0;
        dq.delete();
        dq.push_back(2);
        startRun(1);
        check("err_cleared", timeout_err, 0);
        waitDone();

        // Asynchronous reset in WAIT with filt holding the grant.
        dq.delete();
        dq.push_back(10);
        dq.push_back(10);
        startRun(2);
        waitEn();
        filt_req = 1'b1; filt_row = 16'h0044;
        @(negedge clock);
        check("pre_reset_gnt", gnt, 2'b01);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset", allOut, 0);
        filt_req = 1'b0;
        dq.delete();
        @(negedge clock);
        reset = 1'b0;
        fillRam();
        dl = '{4, 0, 0, 0, 0, 0, 0, 0};
        doRun(1, dl, gc, gt, gd);
        check("restart_count", gc, 1);

        // Randomized runs against the model.
        for (int r = 0; r < 24; r++) begin
            int n;
            fillRam();
            n = int'($urandom_range(1, 5));
            for (int i = 0; i < 8; i++) begin
                if ($urandom_range(0, 7) == 0) dl[i] = int'($urandom_range(16, 20));
                else                           dl[i] = int'($urandom_range(1, 15));
            end
            doRun(n, dl, gc, gt, gd);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish, required finish before %0t", $time);
        $fatal(1);
    end

endmodule
